// File: rtl/aes_spi_block_xfer.sv
// Splits a 128-bit AES block into 16-bit SPI master words and gathers the replies into one block; ready only in IDLE.
// Latency: word 0 is requested the cycle after acceptance, and the result pulses the cycle after the last DONE edge. Optional timeout: AES_SPI_TIMEOUT_EN.
module aes_spi_block_xfer #(
  parameter int WORDS   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [16*WORDS-1:0]   block_in,
  input  logic                  block_valid,
  output logic                  block_ready,
  output logic [16*WORDS-1:0]   block_out,
  output logic                  block_out_valid,
  output logic                  block_err,
  output logic [15:0]           spi_data,
  output logic                  spi_valid,
  input  logic                  spi_done,
  input  logic [15:0]           spi_rdata
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  logic [1:0]             state;
  logic [IW-1:0]          idx;
  logic [WORDS-1:0][15:0] tx_buf;
  logic [WORDS-1:0][15:0] rx_buf;
  logic [WORDS-1:0][15:0] rx_merged;
  logic [WORDS-1:0][15:0] out_buf;
  logic                   done_q;
  logic                   live;
  logic                   done_rise;
  logic                   accept;
  logic                   timed_out;

  // live keeps block_ready low until the first edge after reset releases
  assign block_ready = (state == IDLE) && live;
  assign accept      = block_valid && block_ready;
  assign done_rise   = spi_done && !done_q;
  assign spi_valid   = (state == SEND);
  assign spi_data    = tx_buf[idx];
  assign block_out   = out_buf;

  always_comb begin
    rx_merged      = rx_buf;
    rx_merged[idx] = spi_rdata;
  end

`ifdef AES_SPI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Fires in the last allowed WAIT cycle; a DONE edge in that same cycle still wins.
  assign timed_out = (state == WAIT) && !done_rise && (wait_cnt + CW'(1) == CW'(TIMEOUT));
  assign block_err = timed_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == SEND) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end
`else
  assign timed_out = 1'b0;
  assign block_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= '0;
      tx_buf          <= '0;
      rx_buf          <= '0;
      out_buf         <= '0;
      block_out_valid <= 1'b0;
      done_q          <= 1'b0;
      live            <= 1'b0;
    end else begin
      live            <= 1'b1;
      done_q          <= spi_done;
      block_out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_buf <= block_in;
            rx_buf <= '0;
            idx    <= '0;
            state  <= SEND;
          end
        end
        SEND: state <= WAIT;
        WAIT: begin
          if (done_rise) begin
            rx_buf <= rx_merged;
            if (idx == LAST) begin
              out_buf         <= rx_merged;
              block_out_valid <= 1'b1;
              state           <= IDLE;
            end else begin
              idx   <= idx + IW'(1);
              state <= SEND;
            end
          end else if (timed_out) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_block_xfer.sv
// Directed bench for aes_spi_block_xfer with a behavioural 16-bit SPI master (18 cycles valid-to-DONE).
module tb_aes_spi_block_xfer;
  localparam int WORDS = 8;
  localparam int BW    = 16 * WORDS;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] block_in = '0;
  logic          block_valid = 1'b0;
  logic          block_ready;
  logic [BW-1:0] block_out;
  logic          block_out_valid;
  logic          block_err;
  logic [15:0]   spi_data;
  logic          spi_valid;
  logic          spi_done;
  logic [15:0]   spi_rdata;

  // slave mode: 0 echo MOSI, 1 return ~MOSI, 2 DONE/DATA_OUT driven by hand
  int            mode = 0;
  logic          model_done = 1'b0;
  logic [15:0]   model_rdata = '0;
  logic          man_done = 1'b0;
  logic [15:0]   man_rdata = '0;
  int            scnt = 0;
  logic [15:0]   sword = '0;

  assign spi_done  = (mode == 2) ? man_done  : model_done;
  assign spi_rdata = (mode == 2) ? man_rdata : model_rdata;

  int            cyc = 0;
  int            vcyc[$];
  logic [15:0]   vdat[$];
  int            bcyc[$];
  logic [BW-1:0] bdat[$];
  int            dbl = 0;
  int            errp = 0;
  logic          prev_v = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;

  aes_spi_block_xfer #(.WORDS(WORDS), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset),
    .block_in(block_in), .block_valid(block_valid), .block_ready(block_ready),
    .block_out(block_out), .block_out_valid(block_out_valid), .block_err(block_err),
    .spi_data(spi_data), .spi_valid(spi_valid), .spi_done(spi_done), .spi_rdata(spi_rdata)
  );

  always #5 clock = ~clock;

  initial forever @(posedge clock) cyc++;

  initial forever @(negedge clock) begin
    if (spi_valid) begin
      vcyc.push_back(cyc);
      vdat.push_back(spi_data);
    end
    if (block_out_valid) begin
      bcyc.push_back(cyc);
      bdat.push_back(block_out);
    end
    if (spi_valid && prev_v) dbl++;
    if (block_err) errp++;
    prev_v = spi_valid;
  end

  initial forever @(negedge clock) begin
    if (reset || mode == 2) begin
      scnt       = 0;
      model_done = 1'b0;
    end else begin
      model_done = 1'b0;
      if (scnt > 0) begin
        scnt--;
        if (scnt == 0) begin
          model_done  = 1'b1;
          model_rdata = (mode == 1) ? ~sword : sword;
        end
      end
      if (spi_valid) begin
        sword = spi_data;
        scnt  = 18;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_block(input logic [BW-1:0] data);
    int t;
    t = 0;
    while (!block_ready && t < 300) begin
      step();
      t++;
    end
    check("send_ready_seen", BW'(block_ready), BW'(1));
    block_in    = data;
    block_valid = 1'b1;
    step();
    block_valid = 1'b0;
  endtask

  task automatic wait_bov(input int n);
    int t;
    t = 0;
    while (bdat.size() < n && t < 3000) begin
      step();
      t++;
    end
    check("bov_arrived", BW'(bdat.size() >= n), BW'(1));
  endtask

  task automatic man_pulse(input logic [15:0] d);
    man_rdata = d;
    man_done  = 1'b1;
    step();
    man_done  = 1'b0;
  endtask

  initial begin
    logic [BW-1:0] lpat, blk_a, blk_b, expv, out_before;
    int nv, nb, rdy_hi, early, t;

    lpat  = 128'h000102030405060708090A0B0C0D0E0F;
    blk_a = 128'hDEADBEEF0123456789ABCDEF55AA33CC;
    blk_b = 128'hFEDCBA98765432100F1E2D3C4B5A6978;

    // reset and idle
    repeat (3) step();
    check("ready_in_reset", BW'(block_ready), BW'(0));
    reset = 1'b0;
    step();
    check("ready_after_reset", BW'(block_ready), BW'(1));
    check("out_reset", block_out, '0);
    check("bov_reset", BW'(block_out_valid), BW'(0));
    check("err_reset", BW'(block_err), BW'(0));
    check("spi_data_reset", BW'(spi_data), BW'(0));
    check("spi_valid_reset", BW'(spi_valid), BW'(0));

    // loopback
    mode = 0;
    nv = vdat.size();
    nb = bdat.size();
    send_block(lpat);
    wait_bov(nb + 1);
    repeat (3) step();
    check("loop_nvalid", BW'(vdat.size() - nv), BW'(8));
    check("loop_first_word", BW'(vdat[nv]), BW'(16'h0E0F));
    check("loop_last_word", BW'(vdat[nv+7]), BW'(16'h0001));
    check("loop_nbov", BW'(bdat.size() - nb), BW'(1));
    check("loop_block_out", block_out, lpat);

    // inverting slave, mid-transfer block_valid ignored
    mode = 1;
    nv = vdat.size();
    nb = bdat.size();
    send_block('0);
    rdy_hi = 0;
    for (int k = 0; k < 400 && bdat.size() == nb; k++) begin
      if (k == 40) begin
        block_in    = 128'h11112222333344445555666677778888;
        block_valid = 1'b1;
      end else begin
        block_valid = 1'b0;
      end
      step();
      if (bdat.size() == nb && block_ready) rdy_hi++;
    end
    block_valid = 1'b0;
    check("inv_ready_low", BW'(rdy_hi), BW'(0));
    check("inv_block_out", block_out, {BW{1'b1}});
    repeat (30) step();
    check("inv_ignored_valid", BW'(vdat.size() - nv), BW'(8));
    check("inv_nbov", BW'(bdat.size() - nb), BW'(1));

    // back-to-back with block_valid held
    mode = 0;
    nv = vdat.size();
    nb = bdat.size();
    block_in    = blk_a;
    block_valid = 1'b1;
    step();
    block_in = blk_b;
    wait_bov(nb + 1);
    step();
    block_valid = 1'b0;
    wait_bov(nb + 2);
    repeat (3) step();
    check("b2b_gap", BW'(vcyc[nv+8] - bcyc[nb]), BW'(1));
    check("b2b_a", bdat[nb], blk_a);
    check("b2b_b", bdat[nb+1], blk_b);
    check("b2b_nvalid", BW'(vdat.size() - nv), BW'(16));

    // DONE already high on entry to WAIT
    mode = 2;
    man_rdata = 16'h5A5A;
    man_done  = 1'b1;
    nv = vdat.size();
    nb = bdat.size();
    send_block(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    repeat (4) step();
    check("held_no_capture", BW'(vdat.size() - nv), BW'(1));
    man_done = 1'b0;
    repeat (5) step();
    man_pulse(16'hA5A5);
    check("held_one_capture", BW'(vdat.size() - nv), BW'(2));
    for (int k = 1; k < WORDS; k++) begin
      repeat (3) step();
      man_pulse(16'h1000 + 16'(k));
    end
    wait_bov(nb + 1);
    expv = '0;
    expv[15:0] = 16'hA5A5;
    for (int k = 1; k < WORDS; k++) expv[16*k +: 16] = 16'h1000 + 16'(k);
    check("held_block_out", block_out, expv);
    check("held_nvalid", BW'(vdat.size() - nv), BW'(8));

    // reset in the middle of word 3
    mode = 0;
    nv = vdat.size();
    nb = bdat.size();
    send_block(lpat);
    t = 0;
    while (vdat.size() < nv + 4 && t < 500) begin
      step();
      t++;
    end
    repeat (5) step();
    reset = 1'b1;
    step();
    check("mrst_spi_valid", BW'(spi_valid), BW'(0));
    check("mrst_ready", BW'(block_ready), BW'(0));
    check("mrst_block_out", block_out, '0);
    repeat (2) step();
    reset = 1'b0;
    step();
    check("mrst_ready_after", BW'(block_ready), BW'(1));
    repeat (40) step();
    check("mrst_no_bov", BW'(bdat.size() - nb), BW'(0));

`ifdef AES_SPI_TIMEOUT_EN
    mode = 0;
    nb = bdat.size();
    send_block(blk_a);
    wait_bov(nb + 1);
    step();
    out_before = block_out;
    mode = 2;
    man_done = 1'b0;
    nv = vdat.size();
    nb = bdat.size();
    send_block(blk_b);
    for (int w = 0; w < 2; w++) begin
      repeat (3) step();
      man_pulse(16'h0F0F);
    end
    check("tmo_word2_sent", BW'(vdat.size() - nv), BW'(3));
    early = 0;
    for (int k = 1; k < 64; k++) begin
      step();
      if (block_err) early++;
    end
    check("tmo_no_early_err", BW'(early), BW'(0));
    step();
    check("tmo_err_pulse", BW'(block_err), BW'(1));
    check("tmo_ready_low", BW'(block_ready), BW'(0));
    step();
    check("tmo_ready_after", BW'(block_ready), BW'(1));
    check("tmo_err_one_cycle", BW'(block_err), BW'(0));
    check("tmo_block_out", block_out, out_before);
    check("tmo_no_bov", BW'(bdat.size() - nb), BW'(0));
`else
    check("no_err_pulses", BW'(errp), BW'(0));
`endif

    check("no_double_valid", BW'(dbl), BW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
